// File: rtl/modport_mem.sv
// Single-port word memory with read-modify-write opcodes and a one-owner bus lock.
// Reads and writes from cores other than the current lock owner are dropped.
module modport_mem #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  we,
  input  logic                  read_en,
  input  logic [1:0]            core_id,
  input  logic [3:0]            opcode,
  input  logic                  req,
  output logic                  gnt,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rvalid
);

  // state  | meaning
  // IDLE   | no lock held, every core may access
  // LOCKED | owner holds the bus, other cores' accesses are dropped
  typedef enum logic {IDLE, LOCKED} state_t;

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  state_t                state;
  logic [1:0]            owner;
  logic                  permit;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] wr_word;

  // Permission comes from the registered gnt/owner, so a grant takes effect next cycle.
  assign permit   = !gnt || (core_id == owner);
  assign old_word = mem[addr];

  always_comb begin
    wr_word = data_in;
    case (opcode)
      4'd1:    wr_word = old_word + data_in;
      4'd2:    wr_word = old_word - data_in;
      4'd3:    wr_word = old_word & data_in;
      4'd4:    wr_word = old_word | data_in;
      4'd5:    wr_word = old_word ^ data_in;
      4'd6:    wr_word = ~data_in;
      4'd7:    wr_word = old_word + DATA_WIDTH'(1);
      4'd8:    wr_word = old_word - DATA_WIDTH'(1);
      default: wr_word = data_in;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      state    <= IDLE;
      gnt      <= 1'b0;
      owner    <= 2'd0;
      rvalid   <= 1'b0;
      data_out <= '0;
    end else begin
      rvalid <= 1'b0;
      // Read samples the pre-write word when we and read_en coincide.
      if (permit && read_en) begin
        data_out <= old_word;
        rvalid   <= 1'b1;
      end
      if (permit && we) begin
        mem[addr] <= wr_word;
      end

      case (state)
        IDLE: begin
          if (req) begin
            owner <= core_id;
            state <= LOCKED;
            gnt   <= 1'b1;
          end
        end
        LOCKED: begin
          if (!req) begin
            state <= IDLE;
            gnt   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modport_mem.sv
// Vector-table bench for modport_mem: read data is checked through a scoreboard queue,
// gnt is checked against each vector, and reset behaviour is checked by hand.
module tb_modport_mem;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] addr;
  logic [7:0]  data_in;
  logic        we;
  logic        read_en;
  logic [1:0]  core_id;
  logic [3:0]  opcode;
  logic        req;
  logic        gnt;
  logic [7:0]  data_out;
  logic        rvalid;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb_q [$];

  typedef struct {
    logic        we;
    logic        re;
    logic [10:0] addr;
    logic [7:0]  din;
    logic [3:0]  op;
    logic [1:0]  core;
    logic        req;
    logic        rd_ok;
    logic [7:0]  rdata;
    logic        gnt_exp;
  } vec_t;

  vec_t vecs [$];

  always #5 clk = ~clk;

  modport_mem #(.ADDR_WIDTH(11), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .data_in(data_in), .we(we),
    .read_en(read_en), .core_id(core_id), .opcode(opcode), .req(req),
    .gnt(gnt), .data_out(data_out), .rvalid(rvalid)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic w, input logic r, input logic [10:0] a,
                              input logic [7:0] d, input logic [3:0] o, input logic [1:0] c,
                              input logic rq, input logic ok, input logic [7:0] rd,
                              input logic g);
    vec_t v;
    v.we = w; v.re = r; v.addr = a; v.din = d; v.op = o; v.core = c;
    v.req = rq; v.rd_ok = ok; v.rdata = rd; v.gnt_exp = g;
    return v;
  endfunction

  task automatic idle_inputs();
    we = 1'b0; read_en = 1'b0; addr = '0; data_in = '0;
    opcode = '0; core_id = '0; req = 1'b0;
  endtask

  task automatic check_out(input string tag, input int idx);
    logic [7:0] e;
    total++;
    if (sb_q.size() == 0) begin
      if (rvalid !== 1'b0) begin
        bad++;
        $display("FAIL %s[%0d] rvalid: got %b want 0", tag, idx, rvalid);
      end
    end else begin
      e = sb_q.pop_front();
      if (rvalid !== 1'b1 || data_out !== e) begin
        bad++;
        $display("FAIL %s[%0d] read: got rvalid=%b data=%h want rvalid=1 data=%h",
                 tag, idx, rvalid, data_out, e);
      end
    end
  endtask

  task automatic step(input vec_t v, input string tag, input int idx);
    @(negedge clk);
    we = v.we; read_en = v.re; addr = v.addr; data_in = v.din;
    opcode = v.op; core_id = v.core; req = v.req;
    if (v.rd_ok) sb_q.push_back(v.rdata);
    @(posedge clk);
    #1;
    check_out(tag, idx);
    total++;
    if (gnt !== v.gnt_exp) begin
      bad++;
      $display("FAIL %s[%0d] gnt: got %b want %b", tag, idx, gnt, v.gnt_exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    total++;
    if (gnt !== 1'b0) begin bad++; $display("FAIL %s gnt: got %b want 0", tag, gnt); end
    total++;
    if (rvalid !== 1'b0) begin bad++; $display("FAIL %s rvalid: got %b want 0", tag, rvalid); end
    total++;
    if (data_out !== 8'h00) begin bad++; $display("FAIL %s data_out: got %h want 00", tag, data_out); end
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    reset_n = 1'b1;

    //           we re addr    din    op    core rq ok rdata  gnt
    vecs.push_back(mk(0, 1, 11'h7FF, 8'h00, 4'd0, 2'd0, 0, 1, 8'h00, 0));
    vecs.push_back(mk(1, 0, 11'h123, 8'hA5, 4'd0, 2'd0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 11'h123, 8'h00, 4'd0, 2'd0, 0, 1, 8'hA5, 0));
    vecs.push_back(mk(1, 0, 11'h010, 8'hF0, 4'd0, 2'd0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(1, 0, 11'h010, 8'h20, 4'd1, 2'd0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 11'h010, 8'h00, 4'd0, 2'd0, 0, 1, 8'h10, 0));
    vecs.push_back(mk(1, 0, 11'h000, 8'h00, 4'd8, 2'd0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 11'h000, 8'h00, 4'd0, 2'd0, 0, 1, 8'hFF, 0));
    vecs.push_back(mk(1, 0, 11'h055, 8'h11, 4'd0, 2'd0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(1, 1, 11'h055, 8'h33, 4'd0, 2'd0, 0, 1, 8'h11, 0));
    vecs.push_back(mk(0, 1, 11'h055, 8'h00, 4'd0, 2'd0, 0, 1, 8'h33, 0));
    // remaining opcodes on one word
    vecs.push_back(mk(1, 0, 11'h300, 8'h3C, 4'd0, 2'd0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(1, 0, 11'h300, 8'h0F, 4'd2, 2'd0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 11'h300, 8'h00, 4'd0, 2'd0, 0, 1, 8'h2D, 0));
    vecs.push_back(mk(1, 0, 11'h300, 8'h0F, 4'd3, 2'd0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(1, 0, 11'h300, 8'hF0, 4'd4, 2'd0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(1, 0, 11'h300, 8'hFF, 4'd5, 2'd0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 11'h300, 8'h00, 4'd0, 2'd0, 0, 1, 8'h02, 0));
    vecs.push_back(mk(1, 0, 11'h300, 8'h5A, 4'd6, 2'd0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(1, 0, 11'h300, 8'h00, 4'd7, 2'd0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 11'h300, 8'h00, 4'd0, 2'd0, 0, 1, 8'hA6, 0));
    vecs.push_back(mk(1, 0, 11'h300, 8'h99, 4'd12, 2'd0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 11'h300, 8'h00, 4'd0, 2'd0, 0, 1, 8'h99, 0));
    // increment and subtract wrap
    vecs.push_back(mk(1, 0, 11'h301, 8'hFF, 4'd0, 2'd0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(1, 0, 11'h301, 8'h00, 4'd7, 2'd0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 11'h301, 8'h00, 4'd0, 2'd0, 0, 1, 8'h00, 0));
    vecs.push_back(mk(1, 0, 11'h302, 8'h01, 4'd0, 2'd0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(1, 0, 11'h302, 8'h02, 4'd2, 2'd0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 11'h302, 8'h00, 4'd0, 2'd0, 0, 1, 8'hFF, 0));
    // back-to-back reads
    vecs.push_back(mk(0, 1, 11'h123, 8'h00, 4'd0, 2'd0, 0, 1, 8'hA5, 0));
    vecs.push_back(mk(0, 1, 11'h010, 8'h00, 4'd0, 2'd0, 0, 1, 8'h10, 0));
    vecs.push_back(mk(0, 1, 11'h000, 8'h00, 4'd0, 2'd0, 0, 1, 8'hFF, 0));
    // lock by core 2, foreign accesses dropped
    vecs.push_back(mk(1, 0, 11'h200, 8'h44, 4'd0, 2'd0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 0, 11'h000, 8'h00, 4'd0, 2'd2, 1, 0, 8'h00, 1));
    vecs.push_back(mk(1, 0, 11'h200, 8'h77, 4'd0, 2'd1, 1, 0, 8'h00, 1));
    vecs.push_back(mk(0, 1, 11'h200, 8'h00, 4'd0, 2'd1, 1, 0, 8'h00, 1));
    vecs.push_back(mk(0, 1, 11'h200, 8'h00, 4'd0, 2'd2, 1, 1, 8'h44, 1));
    vecs.push_back(mk(1, 0, 11'h200, 8'h88, 4'd0, 2'd2, 1, 0, 8'h00, 1));
    vecs.push_back(mk(0, 1, 11'h200, 8'h00, 4'd0, 2'd3, 1, 0, 8'h00, 1));
    vecs.push_back(mk(0, 1, 11'h200, 8'h00, 4'd0, 2'd2, 1, 1, 8'h88, 1));
    vecs.push_back(mk(0, 0, 11'h000, 8'h00, 4'd0, 2'd2, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 11'h200, 8'h00, 4'd0, 2'd1, 0, 1, 8'h88, 0));
    // access in the grant cycle is judged as unlocked
    vecs.push_back(mk(1, 0, 11'h201, 8'h55, 4'd0, 2'd3, 1, 0, 8'h00, 1));
    vecs.push_back(mk(0, 1, 11'h201, 8'h00, 4'd0, 2'd0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 11'h201, 8'h00, 4'd0, 2'd0, 0, 1, 8'h55, 0));

    foreach (vecs[i]) step(vecs[i], "vec", i);

    // reset while locked with nonzero data_out
    step(mk(0, 0, 11'h000, 8'h00, 4'd0, 2'd1, 1, 0, 8'h00, 1), "rst_lock", 0);
    step(mk(0, 1, 11'h123, 8'h00, 4'd0, 2'd1, 1, 1, 8'hA5, 1), "rst_lock", 1);
    @(negedge clk);
    reset_n = 1'b0;
    we = 1'b1; read_en = 1'b1; addr = 11'h123; data_in = 8'hEE; req = 1'b1; core_id = 2'd1;
    @(posedge clk);
    #1;
    check_reset_state("mid_lock_reset");
    @(negedge clk);
    reset_n = 1'b1;
    idle_inputs();
    step(mk(0, 1, 11'h123, 8'h00, 4'd0, 2'd0, 0, 1, 8'h00, 0), "post_rst", 0);
    step(mk(0, 1, 11'h200, 8'h00, 4'd0, 2'd0, 0, 1, 8'h00, 0), "post_rst", 1);
    step(mk(0, 1, 11'h055, 8'h00, 4'd0, 2'd0, 0, 1, 8'h00, 0), "post_rst", 2);
    step(mk(0, 0, 11'h000, 8'h00, 4'd0, 2'd0, 0, 0, 8'h00, 0), "post_rst", 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/modport_mem.md
MODPORT_MEM -- requirements
Module: modport_mem

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 11, the memory address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, the memory word width.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset; clk and reset_n are named as below.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  synchronous active-low reset.
REQ-006 addr  input  ADDR_WIDTH  word address for the access.
REQ-007 data_in  input  DATA_WIDTH  write operand.
REQ-008 we  input  1  write/read-modify-write enable.
REQ-009 read_en  input  1  read request.
REQ-010 core_id  input  2  ID of the core issuing the current access or request.
REQ-011 opcode  input  4  write operation select.
REQ-012 req  input  1  bus-lock request from core core_id.
REQ-013 gnt  output  1  lock granted.
REQ-014 data_out  output  DATA_WIDTH  registered read data.
REQ-015 rvalid  output  1  one-cycle pulse marking valid data_out.

Function
REQ-016 Storage SHALL be 2**ADDR_WIDTH words of DATA_WIDTH bits (2048 x 8 by default).
REQ-017 An access (we or read_en) SHALL be permitted when gnt=0, or when gnt=1 and core_id equals the latched owner; any other access SHALL be dropped: no memory change, no rvalid.
REQ-018 A permitted write SHALL update mem[addr] at the sampling edge with result R, where old = mem[addr]:
- opcode 0 R=data_in, 1 R=old+data_in, 2 R=old-data_in (mod 2**DATA_WIDTH, carry/borrow discarded).
- opcode 3 R=old&data_in, 4 R=old|data_in, 5 R=old^data_in, 6 R=~data_in.
- opcode 7 R=old+1, 8 R=old-1, wrapping.
- opcodes 9-15 SHALL behave as opcode 0.
REQ-019 A permitted read SHALL register data_out=mem[addr] and pulse rvalid=1 on the edge after read_en is sampled (latency 1).
REQ-020 rvalid SHALL be 0 in every cycle not following a permitted read; data_out SHALL hold its last value otherwise.
REQ-021 When we and read_en are both high on the same address, the read SHALL return the pre-write value (read-before-write) and the write SHALL commit.
REQ-022 Back-to-back reads SHALL each yield one rvalid pulse, giving full throughput of one read per cycle.
REQ-023 The lock FSM SHALL have states IDLE and LOCKED:
- IDLE with req=1 SHALL latch owner=core_id and go to LOCKED, gnt=1 from the next cycle.
- LOCKED with req=1 SHALL stay LOCKED; core_id changes SHALL NOT alter owner.
- LOCKED with req=0 SHALL go to IDLE, gnt=0 from the next cycle.
REQ-024 Permission in REQ-017 SHALL use the registered gnt/owner of the current cycle, so the access in the grant cycle itself is evaluated as gnt=0.

Reset
REQ-025 While reset_n=0 at a rising edge: gnt=0, rvalid=0, data_out=0, owner=0, state IDLE, and all memory words SHALL be cleared to 0.
REQ-026 Accesses and requests sampled with reset_n=0 SHALL be ignored; reset mid-lock SHALL release gnt on the next edge.
REQ-027 Normal operation SHALL resume on the first edge with reset_n=1.

Verification
REQ-028 Reset, then read addr 0x7FF -> data_out=0x00, rvalid=1 exactly one cycle later.
REQ-029 Write 0xA5 to 0x123 (opcode 0), then read 0x123 -> data_out=0xA5 one cycle after read_en.
REQ-030 Write 0xF0 to 0x010, then write 0x20 opcode 1, then read -> 0x10 (wrap); then opcode 8 on 0x000 -> 0xFF.
REQ-031 Same-cycle we=1 data 0x33 and read_en=1 on 0x055 holding 0x11 -> data_out=0x11, then a later read -> 0x33.
REQ-032 req=1 core_id=2 -> gnt=1 next cycle; write 0x77 from core_id=1 to 0x200 is dropped (read -> old value), while core_id=2 write succeeds; req=0 -> gnt=0 next cycle.
REQ-033 Assert reset_n=0 while LOCKED with data in memory -> gnt=0, rvalid=0, data_out=0, and a later read of any address returns 0x00.
